// File: rtl/inst_fetch_resp_pkg.sv
// Shared widths, constants and FSM encoding for the
// instruction-fetch responder.
package inst_fetch_resp_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;
  localparam int TAG_W       = INST_ADDR_W - 2;

  localparam logic [INST_W-1:0] ZERO_WORD = '0;
  localparam logic [INST_W-1:0] NOP       = ZERO_WORD;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_resp_line_buf.sv
// One-entry fetch line buffer: word tag, data and valid bit,
// with a combinational tag compare against the lookup address.
module inst_fetch_resp_line_buf
  import inst_fetch_resp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fill,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [INST_W-1:0] fill_data,
  input  logic [TAG_W-1:0]  tag,
  output logic              hit,
  output logic [INST_W-1:0] data
);

  logic             buf_valid;
  logic [TAG_W-1:0] buf_addr;

  // capture a returned word (or a NOP on abort) with its tag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      data      <= ZERO_WORD;
    end else if (fill) begin
      buf_valid <= 1'b1;
      buf_addr  <= fill_tag;
      data      <= fill_data;
    end
  end

  assign hit = buf_valid & (buf_addr == tag);

endmodule

// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: serves the PC from a one-entry
// buffer, otherwise fetches over a req/ack port with timeout.
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [INST_ADDR_W-1:0] pc,
  input  logic                   flush,
  output logic [INST_W-1:0]      inst,
  output logic                   stallreq,
  output logic                   inst_adel,
  output logic                   bus_err,
  output logic                   mem_req,
  output logic [INST_ADDR_W-1:0] mem_addr,
  input  logic [INST_W-1:0]      mem_rdata,
  input  logic                   mem_ack
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  fetch_state_t      state;
  fetch_state_t      state_n;
  logic [CNT_W-1:0]  cnt;
  logic [TAG_W-1:0]  req_addr;
  logic              aligned;
  logic              buf_hit;
  logic              hit;
  logic              miss;
  logic              timed_out;
  logic              fill;
  logic [INST_W-1:0] fill_data;
  logic [INST_W-1:0] buf_data;

  assign aligned   = (pc[1:0] == 2'b00);
  assign hit       = ce & aligned & buf_hit;
  assign miss      = ce & aligned & ~buf_hit;
  assign timed_out = (cnt == TMO);

  inst_fetch_resp_line_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .fill      (fill),
    .fill_tag  (req_addr),
    .fill_data (fill_data),
    .tag       (pc[INST_ADDR_W-1:2]),
    .hit       (buf_hit),
    .data      (buf_data)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // next state: ack beats flush, flush beats timeout
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (miss) state_n = S_WAIT;
      S_WAIT: begin
        if (mem_ack)        state_n = S_IDLE;
        else if (flush)     state_n = S_DRAIN;
        else if (timed_out) state_n = S_IDLE;
      end
      S_DRAIN: if (mem_ack || timed_out) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // buffer fill and abort pulse, only while a live request waits
  always_comb begin
    fill      = 1'b0;
    fill_data = mem_rdata;
    bus_err   = 1'b0;
    unique case (state)
      S_WAIT: begin
        if (mem_ack) begin
          fill = 1'b1;
        end else if (!flush && timed_out) begin
          fill      = 1'b1;
          fill_data = NOP;
          bus_err   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // request flop, latched address and per-state timeout counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req  <= 1'b0;
      req_addr <= '0;
      cnt      <= '0;
    end else begin
      mem_req <= (state_n == S_WAIT);
      if (state == S_IDLE && miss)
        req_addr <= pc[INST_ADDR_W-1:2];
      if (state_n != state)
        cnt <= '0;
      else if (state != S_IDLE)
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign inst      = hit ? buf_data : ZERO_WORD;
  assign inst_adel = ce & ~aligned;
  assign stallreq  = (miss | (ce & aligned & (state == S_DRAIN)))
                     ? STOP : NO_STOP;
  assign mem_addr  = (state == S_WAIT) ? {req_addr, 2'b00}
                                       : {pc[INST_ADDR_W-1:2], 2'b00};

endmodule

// File: doc/inst_fetch_resp.md
Name: inst_fetch_resp

Overview:
Responder side of the instruction-fetch interface driven by the PC register. It accepts the fetch enable and address, returns the instruction word, and raises a stall request while the fetch is outstanding. It bridges to a variable-latency instruction memory port using a request/acknowledge handshake. A one-entry line buffer holds the last fetched word and its address, so a held PC is served with no further memory traffic. It sits between pc_reg/if_id and the instruction memory; its stall request feeds ctrl.

Parameters:
TIMEOUT_CYCLES, 255, cycles in WAIT without mem_ack before the fetch is aborted with a bus error.
CNT_W, 8, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous active-low reset.
ce  in  1  fetch enable from the PC register; 0 means no fetch.
pc  in  32  fetch address, byte address.
flush  in  1  pipeline flush from ctrl; cancels any outstanding fetch.
inst  out  32  instruction returned to the IF/ID stage.
stallreq  out  1  fetch-not-ready request to ctrl (combinational).
inst_adel  out  1  misaligned fetch address, pc[1:0] != 0.
bus_err  out  1  one-cycle pulse when a fetch times out.
mem_req  out  1  request to the instruction memory.
mem_addr  out  32  word-aligned memory address, {pc[31:2],2'b00}.
mem_rdata  in  32  memory read data; valid when mem_ack=1.
mem_ack  in  1  memory acknowledge; one cycle per request.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; buf_valid=0; buf_addr=0; buf_data=0; timeout counter=0; mem_req=0; bus_err=0.
- Hit condition: ce=1 & pc[1:0]==0 & buf_valid & buf_addr==pc[31:2]. Combinationally, inst=buf_data and stallreq=0.
- ce=0: inst=0, stallreq=0, inst_adel=0, no request issued. Any outstanding fetch continues to completion.
- Misaligned (ce=1 & pc[1:0]!=0): inst=0, inst_adel=1, stallreq=0, no memory request issued. The exception is handled downstream.
- Miss (ce=1, aligned, not hit): stallreq=1 and inst=0 until the buffer is filled. The PC is held by ctrl meanwhile.
- State machine:
  - IDLE: on a miss, go to WAIT with mem_req=1 registered from the next cycle; latch req_addr=pc[31:2]; clear the timeout counter.
  - WAIT: mem_req=1 and mem_addr={req_addr,00}.
    - mem_ack: buf_data<=mem_rdata, buf_addr<=req_addr, buf_valid<=1, go to IDLE. The next cycle hits, so stallreq drops.
    - flush without ack: go to DRAIN.
    - counter reaches TIMEOUT_CYCLES: go to IDLE, pulse bus_err for 1 cycle, fill the buffer with 0 (NOP) tagged req_addr so the pipeline advances.
  - DRAIN: mem_req=0. Wait for the stray mem_ack and discard its data, then go to IDLE. stallreq=1 for any ce=1 request while in DRAIN. DRAIN also times out after TIMEOUT_CYCLES, returning to IDLE silently.
- Simultaneous mem_ack and flush in WAIT: the data is accepted into the buffer (it is correct for req_addr), go to IDLE. flush never invalidates the buffer.
- A PC change while in WAIT, not possible when ctrl stalls correctly: the request completes for req_addr. The new pc misses and starts a new fetch from IDLE.
- Minimum miss latency: request cycle + 1 ack cycle + 1 hit cycle, i.e. stallreq is high for 2 cycles when memory acks on its first cycle.
- Reset mid-fetch returns to IDLE immediately. A subsequent mem_ack in IDLE is ignored.

Decomposition:
- Shared defines file: state encodings (IDLE/WAIT/DRAIN), the ZeroWord/NOP constant, the InstAddrBus and InstBus widths, and Stop/NoStop.
- Natural sub-module: fetch_line_buf (tag/data/valid register plus hit compare). The FSM and timeout counter stay in the top level.

Test Plan:
- Cold fetch: rst release, ce=1, pc=0x0, memory acks 3 cycles after the request with 0x3401_1100 → stallreq high 5 cycles, then inst=0x3401_1100, stallreq=0, exactly one request observed.
- Held-PC hit: after the above, keep pc=0x0 for 4 cycles → inst constant, mem_req stays 0 throughout.
- Misaligned: ce=1, pc=0x0000_0006 → inst_adel=1, inst=0, stallreq=0, mem_req never asserted.
- Flush in WAIT: miss at pc=0x100, flush on cycle 2, ack with 0xDEAD_BEEF on cycle 4 → buffer unchanged (pc=0x100 still misses afterwards), new request issued only after the ack is drained.
- Timeout: TIMEOUT_CYCLES=4, no ack → bus_err pulses once on cycle 5 of WAIT, inst=0, stallreq drops next cycle.
- Async reset in WAIT: assert rst=0 between clock edges → mem_req=0 and buf_valid=0 immediately; a later ack is ignored.
